// File: rtl/cp0_defs.sv
// Shared CP0 definitions for the exception/ERET sequencer.
// Contents:
//   state_t        - sequencer FSM state encoding
//   Addr*          - CP0 register addresses, {regnum[4:0], sel[2:0]}
//   ExlBit/BdBit   - Status.EXL and Cause.BD bit positions
//   epc_for()      - EPC value for a faulting PC, backing up over a branch for delay slots
package cp0_defs;

   typedef enum logic [2:0] {
      StIdle,
      StExStatus,
      StExCause,
      StExEpc,
      StExBadv,
      StErStatus,
      StErEpc,
      StRedir
   } state_t;

   localparam logic [7:0] AddrStatus   = 8'h60;  // reg 12, sel 0
   localparam logic [7:0] AddrCause    = 8'h68;  // reg 13, sel 0
   localparam logic [7:0] AddrEpc      = 8'h70;  // reg 14, sel 0
   localparam logic [7:0] AddrBadVAddr = 8'h40;  // reg 8, sel 0

   localparam int unsigned ExlBit     = 1;
   localparam int unsigned BdBit      = 31;
   localparam int unsigned ExcCodeLsb = 2;

   // A delay-slot fault restarts at the branch, one word earlier.
   function automatic logic [31:0] epc_for(input logic [31:0] pc, input logic bd);
      return bd ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/cp0_exc_seq.sv
// CP0 exception-entry / ERET sequencer.
// Walks the CP0 register file through a read-modify-write sequence over a
// single shared port, then issues a one-cycle fetch redirect.
//   Exception: Status.EXL set -> Cause -> EPC (only if EXL was clear)
//              -> BadVAddr (optional) -> redirect to EXC_VECTOR.
//   ERET:      Status.EXL clear -> read EPC -> redirect to EPC.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   exc_valid/code/pc/bd        commit-stage exception request (pulse)
//   exc_has_badv/exc_badvaddr   optional BadVAddr update
//   eret_valid                  ERET committed (pulse)
//   cp0_wen/addr/wdata          CP0 write port; cp0_rdata is combinational read of cp0_addr
//   busy                        sequence in progress, upstream holds commit
//   redirect_valid/redirect_pc  one-cycle fetch redirect and flush
module cp0_exc_seq
   import cp0_defs::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        exc_bd,
   input  logic        exc_has_badv,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret_valid,
   output logic        cp0_wen,
   output logic [7:0]  cp0_addr,
   output logic [31:0] cp0_wdata,
   input  logic [31:0] cp0_rdata,
   output logic        busy,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   state_t      state_q, state_d;
   logic [4:0]  code_q, code_d;
   logic [31:0] pc_q, pc_d;
   logic        bd_q, bd_d;
   logic        has_badv_q, has_badv_d;
   logic [31:0] badv_q, badv_d;
   logic        old_exl_q, old_exl_d;
   logic        eret_q, eret_d;   // sequence in flight is an ERET
   logic [31:0] epc_q, epc_d;     // ERET target read back from EPC

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         code_q     <= '0;
         pc_q       <= '0;
         bd_q       <= 1'b0;
         has_badv_q <= 1'b0;
         badv_q     <= '0;
         old_exl_q  <= 1'b0;
         eret_q     <= 1'b0;
         epc_q      <= '0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         pc_q       <= pc_d;
         bd_q       <= bd_d;
         has_badv_q <= has_badv_d;
         badv_q     <= badv_d;
         old_exl_q  <= old_exl_d;
         eret_q     <= eret_d;
         epc_q      <= epc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      pc_d       = pc_q;
      bd_d       = bd_q;
      has_badv_d = has_badv_q;
      badv_d     = badv_q;
      old_exl_d  = old_exl_q;
      eret_d     = eret_q;
      epc_d      = epc_q;

      cp0_wen        = 1'b0;
      cp0_addr       = '0;
      cp0_wdata      = '0;
      redirect_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Exception wins over a simultaneous ERET; the ERET is dropped.
            if (exc_valid) begin
               code_d     = exc_code;
               pc_d       = exc_pc;
               bd_d       = exc_bd;
               has_badv_d = exc_has_badv;
               badv_d     = exc_badvaddr;
               eret_d     = 1'b0;
               state_d    = StExStatus;
            end else if (eret_valid) begin
               eret_d  = 1'b1;
               state_d = StErStatus;
            end
         end
         StExStatus: begin
            cp0_addr         = AddrStatus;
            cp0_wen          = 1'b1;
            cp0_wdata        = cp0_rdata;
            cp0_wdata[ExlBit] = 1'b1;
            old_exl_d        = cp0_rdata[ExlBit];
            state_d          = StExCause;
         end
         StExCause: begin
            cp0_addr                          = AddrCause;
            cp0_wen                           = 1'b1;
            cp0_wdata                         = cp0_rdata;
            cp0_wdata[BdBit]                  = bd_q;
            cp0_wdata[ExcCodeLsb+4:ExcCodeLsb] = code_q;
            state_d                           = StExEpc;
         end
         StExEpc: begin
            // A nested exception (EXL already set) must not clobber EPC.
            cp0_addr  = AddrEpc;
            cp0_wen   = ~old_exl_q;
            cp0_wdata = epc_for(pc_q, bd_q);
            state_d   = has_badv_q ? StExBadv : StRedir;
         end
         StExBadv: begin
            cp0_addr  = AddrBadVAddr;
            cp0_wen   = 1'b1;
            cp0_wdata = badv_q;
            state_d   = StRedir;
         end
         StErStatus: begin
            cp0_addr          = AddrStatus;
            cp0_wen           = 1'b1;
            cp0_wdata         = cp0_rdata;
            cp0_wdata[ExlBit] = 1'b0;
            state_d           = StErEpc;
         end
         StErEpc: begin
            cp0_addr = AddrEpc;
            epc_d    = cp0_rdata;
            state_d  = StRedir;
         end
         StRedir: begin
            redirect_valid = 1'b1;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy        = (state_q != StIdle);
   assign redirect_pc = (state_q == StRedir) ? (eret_q ? epc_q : EXC_VECTOR) : '0;

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Scoreboard bench for cp0_exc_seq: a small CP0 register model answers the
// read port; each request pushes its expected redirect (pc, cycle) and final
// register contents, and a negedge monitor checks them when redirect_valid fires.
module tb_cp0_exc_seq;

   localparam logic [31:0] ExcVec = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        exc_valid = 1'b0;
   logic [4:0]  exc_code = '0;
   logic [31:0] exc_pc = '0;
   logic        exc_bd = 1'b0;
   logic        exc_has_badv = 1'b0;
   logic [31:0] exc_badvaddr = '0;
   logic        eret_valid = 1'b0;
   logic        cp0_wen;
   logic [7:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        busy;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   cp0_exc_seq #(.EXC_VECTOR(ExcVec)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .exc_valid      (exc_valid),
      .exc_code       (exc_code),
      .exc_pc         (exc_pc),
      .exc_bd         (exc_bd),
      .exc_has_badv   (exc_has_badv),
      .exc_badvaddr   (exc_badvaddr),
      .eret_valid     (eret_valid),
      .cp0_wen        (cp0_wen),
      .cp0_addr       (cp0_addr),
      .cp0_wdata      (cp0_wdata),
      .cp0_rdata      (cp0_rdata),
      .busy           (busy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // CP0 register model: Status, Cause, EPC, BadVAddr.
   logic [31:0] st_r = '0, ca_r = '0, ep_r = '0, bv_r = '0;
   logic        pre_en = 1'b0;
   logic [31:0] pre_st = '0, pre_ca = '0, pre_ep = '0, pre_bv = '0;

   always @(posedge clk) begin
      if (pre_en) begin
         st_r <= pre_st; ca_r <= pre_ca; ep_r <= pre_ep; bv_r <= pre_bv;
      end else if (cp0_wen) begin
         case (cp0_addr)
            8'h60: st_r <= cp0_wdata;
            8'h68: ca_r <= cp0_wdata;
            8'h70: ep_r <= cp0_wdata;
            8'h40: bv_r <= cp0_wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         8'h60: cp0_rdata = st_r;
         8'h68: cp0_rdata = ca_r;
         8'h70: cp0_rdata = ep_r;
         8'h40: cp0_rdata = bv_r;
         default: cp0_rdata = '0;
      endcase
   end

   typedef struct {
      logic [31:0] pc;
      int unsigned cyc;
      logic [31:0] st, ca, ep, bv;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor.
   int wen_seen = 0, red_seen = 0;
   always @(negedge clk) begin
      if (cp0_wen === 1'b1) wen_seen++;
      if (redirect_valid === 1'b1) red_seen++;
      if (resetn) begin
         if (busy === 1'b0) chk("idle_quiet", {30'd0, cp0_wen, redirect_valid}, 32'd0);
         if (redirect_valid === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_redirect: got pc %08h, expected none", redirect_pc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("redirect_pc", redirect_pc, e.pc);
               chk("redirect_cycle", cyc, e.cyc);
               chk("status", st_r, e.st);
               chk("cause", ca_r, e.ca);
               chk("epc", ep_r, e.ep);
               chk("badvaddr", bv_r, e.bv);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preset(input logic [31:0] s, c, e, b);
      pre_st = s; pre_ca = c; pre_ep = e; pre_bv = b;
      pre_en = 1'b1;
      step();
      pre_en = 1'b0;
   endtask

   task automatic scramble_inputs();
      exc_code     = 5'($urandom);
      exc_pc       = $urandom;
      exc_bd       = 1'($urandom);
      exc_has_badv = 1'($urandom);
      exc_badvaddr = $urandom;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 20) begin
         step();
         n++;
      end
      chk("seq_terminates", {31'd0, busy}, 32'd0);
      chk("redirect_seen", sb.size(), 32'd0);
      if (sb.size() != 0) sb.delete();
      step();
   endtask

   // Exception: expected result computed from the architectural rules.
   task automatic run_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic hb, input logic [31:0] bva, input logic with_eret,
                          input logic eret_busy);
      exp_t e;
      step();
      e.st  = st_r | 32'h2;
      e.ca  = (ca_r & 32'h7FFF_FF83) | ({27'd0, code} << 2) | (bd ? 32'h8000_0000 : 32'h0);
      e.ep  = st_r[1] ? ep_r : (bd ? pc - 32'd4 : pc);
      e.bv  = hb ? bva : bv_r;
      e.pc  = ExcVec;
      exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
      exc_has_badv = hb; exc_badvaddr = bva; eret_valid = with_eret;
      e.cyc = cyc + (hb ? 5 : 4);
      sb.push_back(e);
      step();
      exc_valid = 1'b0; eret_valid = 1'b0;
      scramble_inputs();
      if (eret_busy) begin
         step();
         eret_valid = 1'b1;
         step();
         eret_valid = 1'b0;
      end
      wait_done();
   endtask

   task automatic run_eret();
      exp_t e;
      step();
      e.st = st_r & ~32'h2;
      e.ca = ca_r; e.ep = ep_r; e.bv = bv_r;
      e.pc = ep_r;
      eret_valid = 1'b1;
      e.cyc = cyc + 3;
      sb.push_back(e);
      step();
      eret_valid = 1'b0;
      wait_done();
   endtask

   initial begin
      logic [31:0] s0, c0, e0;
      int unsigned t0;
      // Reset state.
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_wen", {31'd0, cp0_wen}, 32'd0);
      step();
      resetn = 1'b1;
      step();

      // Basic exception with BadVAddr.
      preset(32'h0, 32'h0, 32'h0, 32'h0);
      run_exc(5'h04, 32'h8000_1000, 1'b0, 1'b1, 32'h3, 1'b0, 1'b0);
      // Delay-slot exception, no BadVAddr.
      preset(32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
      run_exc(5'h0A, 32'h8000_0008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      // Nested: EXL already set, EPC must survive.
      preset(32'h2, 32'h1234_5678, 32'h8000_0ABC, 32'h0);
      run_exc(5'h0C, 32'h8000_4000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      // ERET.
      preset(32'h3, 32'h0, 32'h8000_2000, 32'h0);
      run_eret();
      // Exception and ERET together, then ERET pulse while busy.
      preset(32'h0, 32'h0, 32'h8000_3000, 32'h0);
      run_exc(5'h08, 32'h8000_5000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      // Randomized mix.
      for (int i = 0; i < 40; i++) begin
         int kind;
         preset($urandom, $urandom, {$urandom} & 32'hFFFF_FFFC, $urandom);
         kind = int'($urandom_range(0, 3));
         if (kind == 2) run_eret();
         else run_exc(5'($urandom), {$urandom} & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom),
                      $urandom, kind == 3, 1'($urandom));
      end

      // Reset in the middle of an exception, while in the Cause step.
      preset(32'h0, 32'h5555_0000, 32'h1111_2220, 32'h0);
      s0 = st_r; c0 = ca_r; e0 = ep_r;
      step();
      exc_valid = 1'b1; exc_code = 5'h05; exc_pc = 32'h8000_7000;
      exc_bd = 1'b0; exc_has_badv = 1'b1; exc_badvaddr = 32'h77;
      t0 = cyc;
      step();
      exc_valid = 1'b0;
      while (cyc < t0 + 2) step();
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_wen", {31'd0, cp0_wen}, 32'd0);
      chk("midrst_redirect", {31'd0, redirect_valid}, 32'd0);
      step();
      step();
      resetn = 1'b1;
      wen_seen = 0;
      red_seen = 0;
      repeat (10) step();
      chk("postrst_no_wen", wen_seen, 32'd0);
      chk("postrst_no_redirect", red_seen, 32'd0);
      chk("postrst_status", st_r, s0 | 32'h2);
      chk("postrst_cause", ca_r, c0);
      chk("postrst_epc", ep_r, e0);

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
